mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mips_defs_pkg.sv | 76 +++++++
 rtl/mem_lane_align.sv | 92 +++++++++
 rtl/mem_access_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_defs_pkg
// Description : Shared definitions for the data-memory access path. It holds
//               the memory opcode encodings, the exception codes, the
//               access-controller FSM encoding, and decode helpers that the
//               controller and the lane aligner both use.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs_pkg;

  // Memory opcodes carried on aluop.
  localparam logic [7:0] c_op_lb  = 8'h90;
  localparam logic [7:0] c_op_lh  = 8'h91;
  localparam logic [7:0] c_op_lw  = 8'h92;
  localparam logic [7:0] c_op_lbu = 8'h94;
  localparam logic [7:0] c_op_lhu = 8'h95;
  localparam logic [7:0] c_op_sb  = 8'h98;
  localparam logic [7:0] c_op_sh  = 8'h99;
  localparam logic [7:0] c_op_sw  = 8'h9A;

  // Exception codes reported on exccode.
  localparam logic [4:0] c_exc_none = 5'h00;
  localparam logic [4:0] c_exc_adel = 5'h04;
  localparam logic [4:0] c_exc_ades = 5'h05;
  localparam logic [4:0] c_exc_dbe  = 5'h07;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic      is_mem;
    logic      is_store;
    logic      is_unsigned;
    mem_size_t size;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [7:0] aluop);
    mem_op_t d;
    d = '0;
    case (aluop)
      c_op_lb:  begin d.is_mem = 1'b1; d.size = SZ_BYTE; end
      c_op_lh:  begin d.is_mem = 1'b1; d.size = SZ_HALF; end
      c_op_lw:  begin d.is_mem = 1'b1; d.size = SZ_WORD; end
      c_op_lbu: begin d.is_mem = 1'b1; d.size = SZ_BYTE; d.is_unsigned = 1'b1; end
      c_op_lhu: begin d.is_mem = 1'b1; d.size = SZ_HALF; d.is_unsigned = 1'b1; end
      c_op_sb:  begin d.is_mem = 1'b1; d.size = SZ_BYTE; d.is_store = 1'b1; end
      c_op_sh:  begin d.is_mem = 1'b1; d.size = SZ_HALF; d.is_store = 1'b1; end
      c_op_sw:  begin d.is_mem = 1'b1; d.size = SZ_WORD; d.is_store = 1'b1; end
      default:  d = '0;
    endcase
    return d;
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    logic r;
    case (size)
      SZ_HALF: r = off[0];
      SZ_WORD: r = (off != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane steering for stores and lane
//               selection plus sign/zero extension for loads.
//               LANE_REV=1 : lane 3 holds address offset 0 (words reversed)
//               LANE_REV=0 : lane 0 holds address offset 0
// Ports       : st_size/st_off/st_wdata  -> st_we, st_data   (store side)
//               ld_size/ld_unsigned/ld_off/ld_raw -> ld_data (load side)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mips_defs_pkg::*;
#(
  parameter int LANE_REV = 1
) (
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_we,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [1:0]  w_st_lane;
  logic [1:0]  w_ld_lane;
  logic        w_st_half_hi;
  logic        w_ld_half_hi;
  logic [31:0] w_st_word;
  logic [31:0] w_ld_word;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  // Offset-to-lane mapping. Halfwords are kept in natural order inside their
  // lane pair so that SH/LH round-trip; only full words are byte-reversed.
  generate
    if (LANE_REV != 0) begin : g_lane_rev
      assign w_st_lane    = ~st_off;
      assign w_ld_lane    = ~ld_off;
      assign w_st_half_hi = ~st_off[1];
      assign w_ld_half_hi = ~ld_off[1];
      assign w_st_word    = {st_wdata[7:0], st_wdata[15:8], st_wdata[23:16], st_wdata[31:24]};
      assign w_ld_word    = {ld_raw[7:0], ld_raw[15:8], ld_raw[23:16], ld_raw[31:24]};
    end else begin : g_lane_fwd
      assign w_st_lane    = st_off;
      assign w_ld_lane    = ld_off;
      assign w_st_half_hi = st_off[1];
      assign w_ld_half_hi = ld_off[1];
      assign w_st_word    = st_wdata;
      assign w_ld_word    = ld_raw;
    end
  endgenerate

  assign w_ld_byte = ld_raw[{w_ld_lane, 3'b000} +: 8];
  assign w_ld_half = w_ld_half_hi ? ld_raw[31:16] : ld_raw[15:0];

  always_comb begin
    st_we   = 4'b0000;
    st_data = 32'h0;
    case (mem_size_t'(st_size))
      SZ_BYTE: begin
        st_we   = 4'b0001 << w_st_lane;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_we   = w_st_half_hi ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      SZ_WORD: begin
        st_we   = 4'b1111;
        st_data = w_st_word;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = 32'h0;
    case (mem_size_t'(ld_size))
      SZ_BYTE: ld_data = ld_unsigned ? {24'h0, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: ld_data = ld_unsigned ? {16'h0, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
      SZ_WORD: ld_data = w_ld_word;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage data-memory access controller. Issues one request
//               per accepted load/store, stalls the pipeline until the memory
//               acknowledges (or a timeout expires), then pulses the result.
// Ports       : clk, rst_n (async, active low)
//               pipeline : op_valid_i, aluop_i, addr_i, wdata_i, flush_i
//               memory   : dce_o, dwe_o, daddr_o, dwdata_o, dack_i, drdata_i
//               result   : stall_o, rdata_o, rvalid_o, exccode_o, badvaddr_o
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mips_defs_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int TIMEOUT  = 255,
  parameter int LANE_REV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  output logic              dce_o,
  output logic [3:0]        dwe_o,
  output logic [ADDR_W-1:0] daddr_o,
  output logic [31:0]       dwdata_o,
  input  logic              dack_i,
  input  logic [31:0]       drdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic [4:0]        exccode_o,
  output logic [ADDR_W-1:0] badvaddr_o
);

  localparam logic [9:0] c_timeout = 10'(TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  mem_op_t           w_dec;
  logic              w_misal;
  logic              w_live;
  logic              w_accept;
  logic              w_adr_err;
  logic              w_in_wait;
  logic              w_tmo;
  logic [9:0]        r_cnt;
  logic [9:0]        w_cnt_nxt;
  logic [3:0]        w_st_we;
  logic [31:0]       w_st_data;
  logic [31:0]       w_ld_data;

  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_we;
  logic [31:0]       r_wdata;
  logic              r_store;
  logic              r_unsigned;
  logic [1:0]        r_size;
  logic [31:0]       r_rdata;
  logic [4:0]        r_exc;
  logic              r_flushed;

  assign w_dec     = decode_op(aluop_i);
  assign w_misal   = is_misaligned(w_dec.size, addr_i[1:0]);
  // rst_n gates the IDLE combinational path so every output is low in reset
  // even while the pipeline still presents an instruction.
  assign w_live    = rst_n & op_valid_i & w_dec.is_mem & ~flush_i & (r_state == ST_IDLE);
  assign w_accept  = w_live & ~w_misal;
  assign w_adr_err = w_live & w_misal;
  assign w_in_wait = (r_state == ST_WAIT);
  assign w_cnt_nxt = r_cnt + 10'd1;
  // An acknowledge in the final WAIT cycle beats the timeout.
  assign w_tmo     = w_in_wait & ~dack_i & (w_cnt_nxt == c_timeout);

  mem_lane_align #(
    .LANE_REV (LANE_REV)
  ) u_lane (
    .st_size     (w_dec.size),
    .st_off      (addr_i[1:0]),
    .st_wdata    (wdata_i),
    .st_we       (w_st_we),
    .st_data     (w_st_data),
    .ld_size     (r_size),
    .ld_unsigned (r_unsigned),
    .ld_off      (r_addr[1:0]),
    .ld_raw      (r_rdata),
    .ld_data     (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    dce_o       = 1'b0;
    dwe_o       = 4'b0000;
    daddr_o     = '0;
    dwdata_o    = 32'h0;
    stall_o     = 1'b0;
    rdata_o     = 32'h0;
    rvalid_o    = 1'b0;
    exccode_o   = c_exc_none;
    badvaddr_o  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_WAIT;
          dce_o       = 1'b1;
          dwe_o       = w_dec.is_store ? w_st_we : 4'b0000;
          daddr_o     = {addr_i[ADDR_W-1:2], 2'b00};
          dwdata_o    = w_dec.is_store ? w_st_data : 32'h0;
          stall_o     = 1'b1;
        end else if (w_adr_err) begin
          rvalid_o    = 1'b1;
          exccode_o   = w_dec.is_store ? c_exc_ades : c_exc_adel;
          badvaddr_o  = addr_i;
        end
      end
      ST_WAIT: begin
        dce_o    = 1'b1;
        dwe_o    = r_we;
        daddr_o  = {r_addr[ADDR_W-1:2], 2'b00};
        dwdata_o = r_wdata;
        stall_o  = 1'b1;
        if (dack_i || w_tmo) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        // A flush seen during WAIT lets the transfer finish but hides it.
        if (!r_flushed) begin
          rvalid_o   = 1'b1;
          exccode_o  = r_exc;
          rdata_o    = (r_store || (r_exc != c_exc_none)) ? 32'h0 : w_ld_data;
          badvaddr_o = (r_exc != c_exc_none) ? r_addr : '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 10'd0;
      r_addr     <= '0;
      r_we       <= 4'b0000;
      r_wdata    <= 32'h0;
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'b00;
      r_rdata    <= 32'h0;
      r_exc      <= c_exc_none;
      r_flushed  <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= 10'd0;
      r_addr     <= addr_i;
      r_we       <= w_dec.is_store ? w_st_we : 4'b0000;
      r_wdata    <= w_dec.is_store ? w_st_data : 32'h0;
      r_store    <= w_dec.is_store;
      r_unsigned <= w_dec.is_unsigned;
      r_size     <= w_dec.size;
      r_rdata    <= 32'h0;
      r_exc      <= c_exc_none;
      r_flushed  <= 1'b0;
    end else if (w_in_wait) begin
      r_cnt <= w_cnt_nxt;
      if (flush_i) begin
        r_flushed <= 1'b1;
      end
      if (dack_i) begin
        r_rdata <= drdata_i;
      end else if (w_tmo) begin
        r_exc <= c_exc_dbe;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench for mem_access_ctrl with
//               ADDR_W=32, TIMEOUT=4, LANE_REV=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid_i;
  logic [7:0]  aluop_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        flush_i;
  logic        dce_o;
  logic [3:0]  dwe_o;
  logic [31:0] daddr_o;
  logic [31:0] dwdata_o;
  logic        dack_i;
  logic [31:0] drdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic [4:0]  exccode_o;
  logic [31:0] badvaddr_o;

  int n_tests   = 0;
  int n_fail    = 0;
  int stall_cnt = 0;
  int rv_cnt    = 0;
  int dce_cnt   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W   (32),
    .TIMEOUT  (4),
    .LANE_REV (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid_i (op_valid_i),
    .aluop_i    (aluop_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .flush_i    (flush_i),
    .dce_o      (dce_o),
    .dwe_o      (dwe_o),
    .daddr_o    (daddr_o),
    .dwdata_o   (dwdata_o),
    .dack_i     (dack_i),
    .drdata_i   (drdata_i),
    .stall_o    (stall_o),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .exccode_o  (exccode_o),
    .badvaddr_o (badvaddr_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    if (stall_o)  stall_cnt++;
    if (rvalid_o) rv_cnt++;
    if (dce_o)    dce_cnt++;
  endtask

  task automatic idle_in();
    op_valid_i = 1'b0;
    aluop_i    = 8'h00;
    addr_i     = 32'h0;
    wdata_i    = 32'h0;
    flush_i    = 1'b0;
    dack_i     = 1'b0;
    drdata_i   = 32'h0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd);
    op_valid_i = 1'b1;
    aluop_i    = op;
    addr_i     = a;
    wdata_i    = wd;
    stall_cnt  = 0;
    rv_cnt     = 0;
    dce_cnt    = 0;
  endtask

  // Load acknowledged in the first WAIT cycle (minimum latency).
  task automatic run_load(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] raw, input logic [31:0] exp);
    issue(op, a, 32'h0);
    samp();
    adv();
    dack_i = 1'b1;
    drdata_i = raw;
    samp();
    adv();
    dack_i = 1'b0;
    drdata_i = 32'h0;
    samp();
    check({tag, "_rdata"}, rdata_o, exp);
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'd2);
    idle_in();
    adv();
  endtask

  task automatic run_store(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] exp_we,
                           input logic [31:0] exp_data);
    issue(op, a, wd);
    samp();
    check({tag, "_dwe"}, 32'(dwe_o), 32'(exp_we));
    check({tag, "_dwdata"}, dwdata_o, exp_data);
    adv();
    dack_i = 1'b1;
    samp();
    check({tag, "_wait_dwe"}, 32'(dwe_o), 32'(exp_we));
    check({tag, "_wait_dwdata"}, dwdata_o, exp_data);
    adv();
    dack_i = 1'b0;
    samp();
    check({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
    check({tag, "_exccode"}, 32'(exccode_o), 32'd0);
    check({tag, "_rdata"}, rdata_o, 32'h0);
    idle_in();
    adv();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst_n = 1'b0;
    // Aligned op presented during reset must not leak onto the outputs.
    issue(8'h92, 32'h0000_0100, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dce", 32'(dce_o), 32'd0);
    check("rst_dwe", 32'(dwe_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_exccode", 32'(exccode_o), 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    idle_in();
    adv();
    rst_n = 1'b1;
    adv();

    // LB 0x1003, ack in third WAIT cycle
    issue(8'h90, 32'h0000_1003, 32'h0);
    samp();
    check("lb_dce", 32'(dce_o), 32'd1);
    check("lb_daddr", daddr_o, 32'h0000_1000);
    check("lb_dwe", 32'(dwe_o), 32'd0);
    adv();
    samp();
    adv();
    samp();
    adv();
    dack_i   = 1'b1;
    drdata_i = 32'h1122_3380;
    samp();
    check("lb_hold_daddr", daddr_o, 32'h0000_1000);
    adv();
    dack_i   = 1'b0;
    drdata_i = 32'h0;
    samp();
    check("lb_rvalid", 32'(rvalid_o), 32'd1);
    check("lb_rdata", rdata_o, 32'hFFFF_FF80);
    check("lb_exccode", 32'(exccode_o), 32'd0);
    check("lb_stall_done", 32'(stall_o), 32'd0);
    check("lb_stall_cycles", 32'(stall_cnt), 32'd4);
    idle_in();
    adv();
    samp();
    check("lb_rvalid_once", 32'(rv_cnt), 32'd1);

    // Stores
    run_store("sh", 8'h99, 32'h0000_2002, 32'h0000_BEEF, 4'b0011, 32'hBEEF_BEEF);
    run_store("sb", 8'h98, 32'h0000_0001, 32'h0000_005A, 4'b0100, 32'h5A5A_5A5A);
    run_store("sw", 8'h9A, 32'h0000_0008, 32'h1122_3344, 4'b1111, 32'h4433_2211);

    // More loads: lane choice and extension
    run_load("lbu", 8'h94, 32'h0000_1000, 32'hAB00_0000, 32'h0000_00AB);
    run_load("lb1", 8'h90, 32'h0000_1001, 32'h00FE_0000, 32'hFFFF_FFFE);
    run_load("lh",  8'h91, 32'h0000_6000, 32'h8001_0000, 32'hFFFF_8001);
    run_load("lhu", 8'h95, 32'h0000_6002, 32'h1234_F00D, 32'h0000_F00D);

    // Misaligned LW: same-cycle exception, no request
    issue(8'h92, 32'h0000_3001, 32'h0);
    samp();
    check("adel_dce", 32'(dce_o), 32'd0);
    check("adel_stall", 32'(stall_o), 32'd0);
    check("adel_rvalid", 32'(rvalid_o), 32'd1);
    check("adel_exccode", 32'(exccode_o), 32'h04);
    check("adel_badvaddr", badvaddr_o, 32'h0000_3001);
    idle_in();
    adv();
    samp();
    check("adel_rvalid_after", 32'(rvalid_o), 32'd0);
    check("adel_exccode_after", 32'(exccode_o), 32'd0);

    // Misaligned SH
    issue(8'h99, 32'h0000_2001, 32'h1234);
    samp();
    check("ades_exccode", 32'(exccode_o), 32'h05);
    check("ades_dce", 32'(dce_o), 32'd0);
    idle_in();
    adv();

    // SW timeout
    issue(8'h9A, 32'h0000_4000, 32'h1122_3344);
    samp();
    check("swto_dwe", 32'(dwe_o), 32'hF);
    check("swto_dwdata", dwdata_o, 32'h4433_2211);
    adv();
    for (int i = 0; i < 4; i++) begin
      samp();
      adv();
    end
    samp();
    check("swto_dce_cycles", 32'(dce_cnt), 32'd5);
    check("swto_dce_dropped", 32'(dce_o), 32'd0);
    check("swto_rvalid", 32'(rvalid_o), 32'd1);
    check("swto_exccode", 32'(exccode_o), 32'h07);
    check("swto_badvaddr", badvaddr_o, 32'h0000_4000);
    check("swto_stall", 32'(stall_o), 32'd0);
    idle_in();
    adv();

    // LW with ack in the same cycle the timeout would fire
    issue(8'h92, 32'h0000_5000, 32'h0);
    samp();
    adv();
    for (int i = 0; i < 3; i++) begin
      samp();
      adv();
    end
    dack_i   = 1'b1;
    drdata_i = 32'hAABB_CCDD;
    samp();
    adv();
    dack_i   = 1'b0;
    drdata_i = 32'h0;
    samp();
    check("lwrace_rvalid", 32'(rvalid_o), 32'd1);
    check("lwrace_exccode", 32'(exccode_o), 32'd0);
    check("lwrace_rdata", rdata_o, 32'hDDCC_BBAA);
    idle_in();
    adv();

    // LHU flushed in WAIT
    issue(8'h95, 32'h0000_6002, 32'h0);
    samp();
    adv();
    flush_i = 1'b1;
    samp();
    check("flush_dce_held", 32'(dce_o), 32'd1);
    adv();
    flush_i  = 1'b0;
    dack_i   = 1'b1;
    drdata_i = 32'h1234_F00D;
    samp();
    check("flush_dce_held2", 32'(dce_o), 32'd1);
    adv();
    dack_i   = 1'b0;
    drdata_i = 32'h0;
    samp();
    check("flush_stall_done", 32'(stall_o), 32'd0);
    check("flush_exccode", 32'(exccode_o), 32'd0);
    idle_in();
    adv();
    samp();
    check("flush_no_rvalid", 32'(rv_cnt), 32'd0);

    // Flush in IDLE blocks acceptance
    issue(8'h92, 32'h0000_0100, 32'h0);
    flush_i = 1'b1;
    samp();
    check("iflush_dce", 32'(dce_o), 32'd0);
    check("iflush_stall", 32'(stall_o), 32'd0);
    check("iflush_rvalid", 32'(rvalid_o), 32'd0);
    idle_in();
    adv();

    // Non-memory opcode
    issue(8'h20, 32'h0000_0100, 32'h0);
    samp();
    check("nonmem_dce", 32'(dce_o), 32'd0);
    check("nonmem_rvalid", 32'(rvalid_o), 32'd0);
    idle_in();
    adv();

    // Stray ack in IDLE is ignored
    rv_cnt = 0;
    dack_i = 1'b1;
    samp();
    adv();
    dack_i = 1'b0;
    samp();
    adv();
    samp();
    check("stray_ack_rvalid", 32'(rv_cnt), 32'd0);

    // Reset in the middle of WAIT
    issue(8'h92, 32'h0000_7000, 32'h0);
    samp();
    adv();
    samp();
    check("rstw_dce_before", 32'(dce_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_dce", 32'(dce_o), 32'd0);
    check("rstw_stall", 32'(stall_o), 32'd0);
    idle_in();
    adv();
    adv();
    rst_n  = 1'b1;
    rv_cnt = 0;
    repeat (3) begin
      samp();
      adv();
    end
    check("rstw_no_rvalid", 32'(rv_cnt), 32'd0);
    samp();
    check("rstw_idle_dce", 32'(dce_o), 32'd0);
    adv();

    // Back to work after reset
    run_load("post_rst_lw", 8'h92, 32'h0000_0010, 32'h0102_0304, 32'h0403_0201);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
